lookup_table_ctrl_arbiter: RTL
==============================

// Module: lookup_table_ctrl_arbiter
// PURPOSE
//  Shares the single NoC control port of the IP-rewrite lookup-table controller among
//  N_REQ requesters (e.g. per-app config tiles). Grants one requester round-robin and
//  locks the grant for its whole fixed-length request message. Then waits for the
//  controller's single-flit response and steers it back to that requester.
//  Sits between the local NoC demux and the lookup-table controller.
// PARAMETERS
//  N_REQ         4    number of requesters, >=2
//  MSG_FLITS     2    flits per request message (header + table request), >=1
//  RESP_TIMEOUT  256  cycles to wait for a response (used only with the optional feature)
// PORTS
//  clk            in   1                   clock
//  rst            in   1                   reset; asynchronous, active-high
//  req_val        in   N_REQ               per-requester flit valid
//  req_data       in   N_REQ*NOC_DATA_W    per-requester flit data; requester i at [i*W +: W]
//  req_rdy        out  N_REQ               per-requester flit ready
//  arb_ctrl_val   out  1                   flit valid to table controller
//  arb_ctrl_data  out  NOC_DATA_W          flit data to table controller
//  ctrl_arb_rdy   in   1                   table controller ready
//  ctrl_arb_val   in   1                   response valid from table controller
//  ctrl_arb_data  in   NOC_DATA_W          response flit
//  arb_ctrl_rdy   out  1                   response ready to table controller
//  resp_val       out  N_REQ               response valid, one-hot to the granted requester
//  resp_data      out  NOC_DATA_W          response flit, shared by all requesters
//  resp_rdy       in   N_REQ               per-requester response ready
//  grant_id       out  clog2(N_REQ)        current/last granted index
//  busy           out  1                   high in any state other than IDLE
//  timeout_err    out  1                   sticky response-timeout flag
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, grant_id=0, rr_ptr=N_REQ-1, flit_cnt=0,
//   timeout_err=0; all val/rdy outputs are 0.
//  States: IDLE -> FWD -> WAIT_RESP -> IDLE.
//  IDLE: find the first req_val[i] set, searching from (rr_ptr+1) mod N_REQ upward with
//   wrap-around. On a hit, register grant_id=i, set rr_ptr=i, clear flit_cnt, go to FWD.
//   The grant takes effect the next cycle. No flit is accepted in IDLE: req_rdy=0.
//  FWD: pass-through with no added latency.
//   arb_ctrl_val=req_val[g], arb_ctrl_data=req_data[g], req_rdy[g]=ctrl_arb_rdy.
//   Every other req_rdy bit is 0.
//   Each handshake (val&rdy) increments flit_cnt.
//   On the handshake with flit_cnt==MSG_FLITS-1, go to WAIT_RESP.
//   A requester may drop req_val mid-message; the grant is held until all flits have passed.
//  WAIT_RESP: arb_ctrl_rdy=resp_rdy[g], resp_val[g]=ctrl_arb_val, resp_data=ctrl_arb_data.
//   All other resp_val bits are 0. On the response handshake, go to IDLE.
//  Throughput: one message per MSG_FLITS+2 cycles at best (1 arb + flits + 1 resp).
//  Fairness: a requester that was just granted has lowest priority on the next arbitration.
//   If all N_REQ requesters are valid, each is served within N_REQ messages.
//  Simultaneous events:
//   - A requester raising val while another message is in flight waits for IDLE.
//   - ctrl_arb_val asserted outside WAIT_RESP is not accepted (arb_ctrl_rdy=0).
//  Reset mid-message abandons the transfer immediately. The table controller is reset
//   together with this block.
//  busy=(state!=IDLE).
// CONFIGURATION
//  LOOKUP_CTRL_ARB_RESP_TIMEOUT_EN defined:
//   - A wait counter clears on entry to WAIT_RESP and increments each cycle in WAIT_RESP.
//   - If it reaches RESP_TIMEOUT-1 with no response handshake: set timeout_err (sticky
//     until rst) and go to IDLE without a response to the requester.
//   - If the response handshake lands on that same cycle, the handshake wins and
//     timeout_err stays 0.
//  Not defined: no counter; WAIT_RESP waits indefinitely; timeout_err is tied to 0.
// TESTING
//  1. Single requester: req 2 sends hdr 0xA1 and body 0xB2, ctrl returns 0xC3
//     -> ctrl sees 0xA1,0xB2 in order; resp_val=4'b0100 with 0xC3; grant_id=2.
//  2. All 4 requesters valid from reset, 3 back-to-back messages each
//     -> grant order 0,1,2,3,0,1,2,3,...; no flit interleaving across requesters.
//  3. Backpressure: ctrl_arb_rdy toggles 1,0,0,1; resp_rdy[g] held 0 for 5 cycles
//     -> flits held stable, no loss or duplication; response delivered once.
//  4. Granted requester drops val for 3 cycles between flits while req 1 is valid
//     -> req_rdy[1] stays 0 until the message completes.
//  5. Assert rst in FWD after 1 flit -> all outputs 0 the same cycle; the next grant
//     follows from rr_ptr=N_REQ-1, i.e. requester 0 first.
//  6. (_EN, RESP_TIMEOUT=8) no response from ctrl -> timeout_err=1 after 8 cycles in
//     WAIT_RESP; state IDLE; the next request is served normally.

Source files
------------

// File: rtl/lookup_table_ctrl_arbiter.sv
// Round-robin arbiter sharing the lookup-table controller NoC port among N_REQ requesters.
// Define LOOKUP_CTRL_ARB_RESP_TIMEOUT_EN to enable the response-timeout counter.
module lookup_table_ctrl_arbiter #(
    parameter int N_REQ        = 4,
    parameter int MSG_FLITS    = 2,
    parameter int RESP_TIMEOUT = 256,
    parameter int NOC_DATA_W   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_val,
    input  logic [N_REQ*NOC_DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]              req_rdy,
    output logic                          arb_ctrl_val,
    output logic [NOC_DATA_W-1:0]         arb_ctrl_data,
    input  logic                          ctrl_arb_rdy,
    input  logic                          ctrl_arb_val,
    input  logic [NOC_DATA_W-1:0]         ctrl_arb_data,
    output logic                          arb_ctrl_rdy,
    output logic [N_REQ-1:0]              resp_val,
    output logic [NOC_DATA_W-1:0]         resp_data,
    input  logic [N_REQ-1:0]              resp_rdy,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int GW = $clog2(N_REQ);
    localparam int FW = (MSG_FLITS > 1) ? $clog2(MSG_FLITS) : 1;

    if (N_REQ < 2 || MSG_FLITS < 1 || RESP_TIMEOUT < 2) begin : g_param_check
        $error("lookup_table_ctrl_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        WAIT_RESP
    } state_t;

    state_t          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   rr_q;
    logic [FW-1:0]   flit_q;

    logic            hit;
    logic [GW-1:0]   pick;
    logic [GW-1:0]   scan;
    logic            fwd_hs;
    logic            resp_hs;

    // Search starts just after the last grant, so the previous winner is scanned last.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        scan = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan = GW'((int'(rr_q) + k) % N_REQ);
            if (!hit && req_val[scan]) begin
                hit  = 1'b1;
                pick = scan;
            end
        end
    end

    always_comb begin
        req_rdy       = '0;
        arb_ctrl_val  = 1'b0;
        arb_ctrl_data = '0;
        arb_ctrl_rdy  = 1'b0;
        resp_val      = '0;
        resp_data     = '0;
        unique case (state_q)
            FWD: begin
                req_rdy[grant_q] = ctrl_arb_rdy;
                arb_ctrl_val     = req_val[grant_q];
                arb_ctrl_data    = req_data[int'(grant_q)*NOC_DATA_W +: NOC_DATA_W];
            end
            WAIT_RESP: begin
                arb_ctrl_rdy      = resp_rdy[grant_q];
                resp_val[grant_q] = ctrl_arb_val;
                resp_data         = ctrl_arb_data;
            end
            default: ;
        endcase
    end

    assign fwd_hs   = (state_q == FWD) && arb_ctrl_val && ctrl_arb_rdy;
    assign resp_hs  = (state_q == WAIT_RESP) && ctrl_arb_val && arb_ctrl_rdy;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;

`ifdef LOOKUP_CTRL_ARB_RESP_TIMEOUT_EN
    localparam int TW = $clog2(RESP_TIMEOUT);

    logic [TW-1:0] wait_q;
    logic          tmo_q;

    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= GW'(N_REQ - 1);
            flit_q  <= '0;
`ifdef LOOKUP_CTRL_ARB_RESP_TIMEOUT_EN
            wait_q  <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        grant_q <= pick;
                        rr_q    <= pick;
                        flit_q  <= '0;
                        state_q <= FWD;
                    end
                end
                FWD: begin
                    if (fwd_hs) begin
                        flit_q <= flit_q + FW'(1);
                        if (flit_q == FW'(MSG_FLITS - 1)) begin
                            state_q <= WAIT_RESP;
`ifdef LOOKUP_CTRL_ARB_RESP_TIMEOUT_EN
                            wait_q  <= '0;
`endif
                        end
                    end
                end
                WAIT_RESP: begin
                    if (resp_hs) begin
                        state_q <= IDLE;
`ifdef LOOKUP_CTRL_ARB_RESP_TIMEOUT_EN
                    // A response landing on the final wait cycle still wins.
                    end else if (wait_q == TW'(RESP_TIMEOUT - 1)) begin
                        tmo_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wait_q  <= wait_q + TW'(1);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
